// File: rtl/axi_lite_arith_pkg.sv
// Shared definitions for the AXI4-Lite arithmetic register array.
// Holds the response codes, the per-channel register offsets, the CTRL/STAT
// bit positions, the write/read state encodings and the signed-overflow
// helper used by each arithmetic lane.
package axi_lite_arith_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register offsets inside one 16-byte channel window
    localparam logic [3:0] OFF_OPA    = 4'h0;
    localparam logic [3:0] OFF_OPB    = 4'h4;
    localparam logic [3:0] OFF_RESULT = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    // CTRL/STAT bit positions
    localparam int CTRL_MODE  = 0;
    localparam int CTRL_CARRY = 1;
    localparam int CTRL_OVF   = 2;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_CALC,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Two's-complement overflow from the sign bits of the operands and result.
    // Add overflows when equal-signed operands give a result of the other sign;
    // subtract overflows when differently-signed operands flip the sign of A.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic sub);
        logic same_sign;
        same_sign = (a_msb == b_msb);
        return (sub ? !same_sign : same_sign) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/axi_lite_arith_array_arith_lane.sv
// One arithmetic channel: registers RESULT, CARRY and OVF from the current
// operands when calc pulses.
// Ports: clk, rst (sync, active-high), calc (one-cycle update strobe),
//        opa/opb (operands), mode (0 add, 1 sub),
//        result/carry/ovf (registered outputs).
module arith_lane
    import axi_lite_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calc,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  ovf
);

    logic [DATA_WIDTH:0]          wide;
    logic signed [DATA_WIDTH-1:0] sum_p0;
    logic                         ovf_p0;

    // The extra top bit is carry-out for add and borrow for sub (wraps when A < B)
    always_comb begin
        wide   = mode ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});
        sum_p0 = wide[DATA_WIDTH-1:0];
        ovf_p0 = signed_ovf(opa[DATA_WIDTH-1], opb[DATA_WIDTH-1], sum_p0[DATA_WIDTH-1], mode);
    end

    // Stage boundary: computed values become visible on the calc edge
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else if (calc) begin
            result <= sum_p0;
            carry  <= wide[DATA_WIDTH];
            ovf    <= ovf_p0;
        end
    end

endmodule

// File: rtl/axi_lite_arith_array.sv
// AXI4-Lite slave exposing NUM_CH add/sub channels. Each channel has OPA,
// OPB, RESULT and CTRL/STAT registers in a 16-byte window. A write commits
// its register on the edge both address and data are held, the lane result
// follows one cycle later together with bvalid.
// Ports: s1_axi_aclk/s1_axi_areset (clock, sync active-high reset) and the
//        standard AXI4-Lite AW, W, B, AR, R channels.
module axi_lite_arith_array
    import axi_lite_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);

    localparam int          STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned MAP_BYTES = NUM_CH * 16;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    // Held low through reset so the ready outputs stay 0 until the first
    // cycle after reset deasserts
    logic ready_en;

    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  wr_ok_q;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic [DATA_WIDTH-1:0] opa    [NUM_CH];
    logic [DATA_WIDTH-1:0] opb    [NUM_CH];
    logic                  mode   [NUM_CH];
    logic [DATA_WIDTH-1:0] result [NUM_CH];
    logic                  carry  [NUM_CH];
    logic                  ovf    [NUM_CH];
    logic                  calc   [NUM_CH];

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [DATA_WIDTH-1:0] rd_val;

    function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (32'(a) < MAP_BYTES);
    endfunction

    function automatic logic ch_hit(input logic [ADDR_WIDTH-1:0] a, input int c);
        return (a >> 4) == ADDR_WIDTH'(c);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old,
                                                          input logic [DATA_WIDTH-1:0] data,
                                                          input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    assign aw_hs = s1_axi_awvalid && s1_axi_awready;
    assign w_hs  = s1_axi_wvalid && s1_axi_wready;
    assign ar_hs = s1_axi_arvalid && s1_axi_arready;

    // Whichever half arrived first was latched; the other comes straight from the bus
    assign wr_addr = (w_state == W_HAVE_A) ? aw_addr_q : s1_axi_awaddr;
    assign wr_data = (w_state == W_HAVE_D) ? w_data_q  : s1_axi_wdata;
    assign wr_strb = (w_state == W_HAVE_D) ? w_strb_q  : s1_axi_wstrb;
    assign commit  = (w_state == W_IDLE   && aw_hs && w_hs) ||
                     (w_state == W_HAVE_A && w_hs) ||
                     (w_state == W_HAVE_D && aw_hs);

    // State registers
    always_ff @(posedge s1_axi_aclk) begin
        if (s1_axi_areset) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            ready_en <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_CALC;
                else if (aw_hs)    w_next = W_HAVE_A;
                else if (w_hs)     w_next = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)  w_next = W_CALC;
            W_HAVE_D: if (aw_hs) w_next = W_CALC;
            W_CALC:              w_next = W_RESP;
            W_RESP:   if (s1_axi_bvalid && s1_axi_bready) w_next = W_IDLE;
            default:             w_next = W_IDLE;
        endcase
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (s1_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        s1_axi_awready = ready_en && (w_state == W_IDLE || w_state == W_HAVE_D);
        s1_axi_wready  = ready_en && (w_state == W_IDLE || w_state == W_HAVE_A);
        s1_axi_bvalid  = (w_state == W_RESP);
        s1_axi_bresp   = bresp_q;
        s1_axi_arready = ready_en && (r_state == R_IDLE);
        s1_axi_rvalid  = (r_state == R_DATA);
        s1_axi_rdata   = rdata_q;
        s1_axi_rresp   = rresp_q;
    end

    // Read mux over the live registers; sampled on the AR handshake edge so a
    // write committing on that same edge is not yet visible
    always_comb begin
        rd_val = '0;
        if (addr_mapped(s1_axi_araddr)) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit(s1_axi_araddr, c)) begin
                    case (s1_axi_araddr[3:0])
                        OFF_OPA:    rd_val = opa[c];
                        OFF_OPB:    rd_val = opb[c];
                        OFF_RESULT: rd_val = result[c];
                        OFF_CTRL: begin
                            rd_val[CTRL_MODE]  = mode[c];
                            rd_val[CTRL_CARRY] = carry[c];
                            rd_val[CTRL_OVF]   = ovf[c];
                        end
                        default:    rd_val = '0;
                    endcase
                end
            end
        end
    end

    // Bus capture and register file
    always_ff @(posedge s1_axi_aclk) begin
        if (s1_axi_areset) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            wr_ok_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int c = 0; c < NUM_CH; c++) begin
                opa[c]  <= '0;
                opb[c]  <= '0;
                mode[c] <= 1'b0;
            end
        end else begin
            if (aw_hs) aw_addr_q <= s1_axi_awaddr;
            if (w_hs) begin
                w_data_q <= s1_axi_wdata;
                w_strb_q <= s1_axi_wstrb;
            end
            if (commit) begin
                wr_ok_q <= addr_mapped(wr_addr) && (wr_addr[3:0] != OFF_RESULT);
                bresp_q <= (addr_mapped(wr_addr) && (wr_addr[3:0] != OFF_RESULT)) ? RESP_OKAY : RESP_SLVERR;
                if (addr_mapped(wr_addr)) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ch_hit(wr_addr, c)) begin
                            case (wr_addr[3:0])
                                OFF_OPA:  opa[c] <= merge_bytes(opa[c], wr_data, wr_strb);
                                OFF_OPB:  opb[c] <= merge_bytes(opb[c], wr_data, wr_strb);
                                OFF_CTRL: if (wr_strb[0]) mode[c] <= wr_data[CTRL_MODE];
                                default:  ;
                            endcase
                        end
                    end
                end
            end
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= addr_mapped(s1_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Lanes recompute on the W_CALC exit edge for the channel just written
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign calc[c] = (w_state == W_CALC) && wr_ok_q && ch_hit(aw_addr_q, c);

        arith_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk    (s1_axi_aclk),
            .rst    (s1_axi_areset),
            .calc   (calc[c]),
            .opa    (opa[c]),
            .opb    (opb[c]),
            .mode   (mode[c]),
            .result (result[c]),
            .carry  (carry[c]),
            .ovf    (ovf[c])
        );
    end

endmodule
